periph_hs_arbiter: RTL and testbench

- Shares one peripheral send/ack handshake port among N_REQ CPU-side requesters. Each requester uses the same 4-phase protocol as a single CPU talking to the peripheral.
- Grants requesters round-robin, forwards the latched data word, and relays ack back to the granted requester.
- A watchdog aborts any transaction the peripheral never acknowledges.
- Sits between the CPU FSM instances and the peripheral FSM.

---
 rtl/periph_hs_pkg.sv | 15 +
 rtl/periph_rr_pick.sv | 38 +++
 rtl/periph_hs_arbiter.sv | 140 ++++++++++++++
 tb/tb_periph_hs_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_hs_pkg.sv
// Shared definitions for the peripheral handshake arbiter: FSM state codes
// and default parameter values used by the top and its round-robin picker.
package periph_hs_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] ACK   = 3'd2;
  localparam logic [2:0] REL   = 3'd3;
  localparam logic [2:0] ABORT = 3'd4;

  localparam int N_REQ_DEF   = 4;
  localparam int DW_DEF      = 2;
  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/periph_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping around past N_REQ-1 back to 0.
module periph_rr_pick
  import periph_hs_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int GW = $clog2(N_REQ);

  logic [GW:0]   sum;
  logic [GW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // Candidate index (ptr + k) mod N_REQ; ptr is always below N_REQ.
      sum = {1'b0, ptr} + (GW+1)'(k);
      if (sum >= (GW+1)'(N_REQ)) begin
        sum = sum - (GW+1)'(N_REQ);
      end
      cand = sum[GW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/periph_hs_arbiter.sv
// Round-robin arbiter sharing one 4-phase send/ack peripheral port among
// N_REQ requesters, with a watchdog that aborts unacknowledged requests.
module periph_hs_arbiter
  import periph_hs_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk2,
  input  logic                     rst2,
  input  logic [N_REQ-1:0]         cpu_send,
  input  logic [N_REQ*DW-1:0]      cpu_dado,
  output logic [N_REQ-1:0]         cpu_ack,
  output logic [N_REQ-1:0]         cpu_nak,
  output logic                     per_send,
  output logic [DW-1:0]            per_dado,
  input  logic                     per_ack,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     err_valid
);

  localparam int GW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic [GW-1:0] ptr;
  logic [WW-1:0] wdog;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic [DW-1:0] pick_dado;
  logic [GW-1:0] next_ptr;
  logic          owner_send;

  function automatic logic [N_REQ-1:0] onehot(input logic [GW-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  periph_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (cpu_send),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_dado = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_idx == GW'(k)) begin
        pick_dado = cpu_dado[k*DW +: DW];
      end
    end
  end

  assign next_ptr   = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign owner_send = cpu_send[grant_id];

  always_ff @(posedge clk2 or negedge rst2) begin
    if (!rst2) begin
      state     <= IDLE;
      ptr       <= '0;
      wdog      <= '0;
      cpu_ack   <= '0;
      cpu_nak   <= '0;
      per_send  <= 1'b0;
      per_dado  <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      err_valid <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      case (state)
        IDLE: begin
          // per_ack is deliberately ignored here; only requests matter.
          if (pick_found) begin
            state    <= REQ;
            grant_id <= pick_idx;
            per_dado <= pick_dado;
            per_send <= 1'b1;
            wdog     <= '0;
            busy     <= 1'b1;
          end
        end
        REQ: begin
          // An ack arriving on the final watchdog cycle still completes.
          if (per_ack) begin
            state   <= ACK;
            cpu_ack <= onehot(grant_id);
          end else if (wdog == WDOG_LAST) begin
            state     <= ABORT;
            per_send  <= 1'b0;
            err_valid <= 1'b1;
            cpu_nak   <= onehot(grant_id);
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        ACK: begin
          if (!owner_send) begin
            state    <= REL;
            per_send <= 1'b0;
          end
        end
        REL: begin
          if (!per_ack) begin
            state   <= IDLE;
            cpu_ack <= '0;
            ptr     <= next_ptr;
            busy    <= 1'b0;
          end
        end
        ABORT: begin
          // Both sides must be idle before the port is offered again.
          if (!owner_send && !per_ack) begin
            state   <= IDLE;
            cpu_nak <= '0;
            ptr     <= next_ptr;
            busy    <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          per_send <= 1'b0;
          cpu_ack  <= '0;
          cpu_nak  <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_periph_hs_arbiter.sv
// Directed bench for periph_hs_arbiter with a transaction-level reference model
// checked every cycle, plus hand-computed expectations for each scenario.
module tb_periph_hs_arbiter;

  localparam int N  = 4;
  localparam int DW = 2;
  localparam int TO = 16;

  logic           clk2 = 1'b0;
  logic           rst2 = 1'b0;
  logic [N-1:0]   cpu_send = '0;
  logic [N*DW-1:0] cpu_dado = '0;
  logic [N-1:0]   cpu_ack;
  logic [N-1:0]   cpu_nak;
  logic           per_send;
  logic [DW-1:0]  per_dado;
  logic           per_ack = 1'b0;
  logic [1:0]     grant_id;
  logic           busy;
  logic           err_valid;

  int n_cmp = 0;
  int n_err = 0;
  bit model_en = 1'b0;

  periph_hs_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
    .clk2      (clk2),
    .rst2      (rst2),
    .cpu_send  (cpu_send),
    .cpu_dado  (cpu_dado),
    .cpu_ack   (cpu_ack),
    .cpu_nak   (cpu_nak),
    .per_send  (per_send),
    .per_dado  (per_dado),
    .per_ack   (per_ack),
    .grant_id  (grant_id),
    .busy      (busy),
    .err_valid (err_valid)
  );

  always #5 clk2 = ~clk2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port and which part of the handshake it is in.
  // phase: 0 port free, 1 waiting on peripheral, 2 acknowledged,
  //        3 releasing, 4 aborted after watchdog expiry
  int         m_owner;
  int         m_phase;
  int         m_age;
  int         m_next;
  int         m_gid;
  logic [1:0] m_dado;
  bit         m_err;

  always @(posedge clk2 or negedge rst2) begin
    if (!rst2) begin
      m_owner = -1; m_phase = 0; m_age = 0; m_next = 0;
      m_gid = 0; m_dado = '0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      case (m_phase)
        0: begin
          for (int k = 0; k < N; k++) begin
            int j;
            j = (m_next + k) % N;
            if (m_owner < 0 && cpu_send[j]) begin
              m_owner = j; m_gid = j; m_dado = cpu_dado[j*DW +: DW];
              m_age = 0; m_phase = 1;
            end
          end
        end
        1: begin
          if (per_ack) m_phase = 2;
          else if (m_age == TO - 1) begin m_phase = 4; m_err = 1'b1; end
          else m_age++;
        end
        2: if (!cpu_send[m_owner]) m_phase = 3;
        3: if (!per_ack) begin m_next = (m_owner + 1) % N; m_owner = -1; m_phase = 0; end
        default: if (!cpu_send[m_owner] && !per_ack) begin
          m_next = (m_owner + 1) % N; m_owner = -1; m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk2) begin
    if (model_en && rst2) begin
      logic [N-1:0] own;
      own = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      chk("m_per_send", 32'(per_send), 32'(m_phase == 1 || m_phase == 2));
      chk("m_per_dado", 32'(per_dado), 32'(m_dado));
      chk("m_grant_id", 32'(grant_id), 32'(m_gid));
      chk("m_cpu_ack", 32'(cpu_ack), (m_phase == 2 || m_phase == 3) ? 32'(own) : 32'd0);
      chk("m_cpu_nak", 32'(cpu_nak), (m_phase == 4) ? 32'(own) : 32'd0);
      chk("m_busy", 32'(busy), 32'(m_phase != 0));
      chk("m_err_valid", 32'(err_valid), 32'(m_err));
    end
  end

  task automatic do_reset();
    rst2 = 1'b0; cpu_send = '0; per_ack = 1'b0;
    repeat (2) @(negedge clk2);
    rst2 = 1'b1;
  endtask

  task automatic wait_send_high(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk2);
      if (per_send) ok = 1'b1;
    end
    if (!ok) chk("wait_per_send", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int order [5];
    int ng;
    int hi_cnt;
    int err_cnt;
    bit ps_prev;
    bit saw_idle;

    // Reset state
    @(negedge clk2); @(negedge clk2);
    chk("rst_per_send", 32'(per_send), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    rst2 = 1'b1;
    model_en = 1'b1;

    // 1: single transfer from requester 2
    cpu_dado = 8'b0011_0000;
    cpu_send = 4'b0100;
    wait_send_high(5);
    chk("t1_per_send", 32'(per_send), 32'd1);
    chk("t1_per_dado", 32'(per_dado), 32'd3);
    chk("t1_grant_id", 32'(grant_id), 32'd2);
    repeat (2) @(negedge clk2);
    per_ack = 1'b1;
    @(negedge clk2);
    chk("t1_cpu_ack", 32'(cpu_ack), 32'b0100);
    cpu_send = '0;
    @(negedge clk2);
    chk("t1_rel_per_send", 32'(per_send), 32'd0);
    chk("t1_rel_cpu_ack", 32'(cpu_ack), 32'b0100);
    per_ack = 1'b0;
    @(negedge clk2);
    chk("t1_done_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("t1_done_busy", 32'(busy), 32'd0);
    cpu_send = 4'b1001;
    @(negedge clk2);
    chk("t1_ptr3_grant", 32'(grant_id), 32'd3);
    per_ack = 1'b1;
    @(negedge clk2);
    cpu_send = '0;
    @(negedge clk2);
    per_ack = 1'b0;
    @(negedge clk2);

    // 2: round-robin with all requesters active and a responsive peripheral
    do_reset();
    cpu_send = 4'b1111;
    ng = 0; ps_prev = 1'b0; saw_idle = 1'b0;
    for (int c = 0; c < 80 && ng < 5; c++) begin
      @(negedge clk2);
      if (per_send && !ps_prev) begin
        order[ng] = int'(grant_id);
        if (ng > 0) chk("t2_idle_gap", 32'(saw_idle), 32'd1);
        saw_idle = 1'b0;
        ng++;
      end
      if (!busy) saw_idle = 1'b1;
      ps_prev = per_send;
      per_ack = per_send;
      for (int i = 0; i < N; i++) cpu_send[i] = !cpu_ack[i];
    end
    chk("t2_grants", 32'(ng), 32'd5);
    for (int i = 0; i < 5; i++) chk("t2_order", 32'(order[i]), 32'(i % 4));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk2);
      per_ack = per_send;
      cpu_send = '0;
    end
    per_ack = 1'b0;
    @(negedge clk2);

    // 3: watchdog timeout on requester 0
    do_reset();
    cpu_send = 4'b0001;
    wait_send_high(5);
    hi_cnt = 1; err_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk2);
      if (err_valid) err_cnt++;
      if (!per_send) break;
      hi_cnt++;
    end
    chk("t3_send_cycles", 32'(hi_cnt), 32'd16);
    chk("t3_err_now", 32'(err_valid), 32'd1);
    chk("t3_cpu_nak", 32'(cpu_nak), 32'b0001);
    @(negedge clk2);
    chk("t3_err_pulse", 32'(err_valid), 32'd0);
    chk("t3_nak_hold", 32'(cpu_nak), 32'b0001);
    cpu_send = '0;
    @(negedge clk2);
    chk("t3_nak_clr", 32'(cpu_nak), 32'd0);
    chk("t3_busy_clr", 32'(busy), 32'd0);
    chk("t3_err_total", 32'(err_cnt), 32'd1);
    cpu_send = 4'b0011;
    @(negedge clk2);
    chk("t3_ptr1_grant", 32'(grant_id), 32'd1);

    // 4: asynchronous reset while in ACK
    per_ack = 1'b1;
    @(negedge clk2);
    chk("t4_in_ack", 32'(cpu_ack), 32'b0010);
    #2 rst2 = 1'b0;
    #1;
    chk("t4_async_per_send", 32'(per_send), 32'd0);
    chk("t4_async_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("t4_async_busy", 32'(busy), 32'd0);
    cpu_send = 4'b0010; per_ack = 1'b0;
    @(negedge clk2); @(negedge clk2);
    rst2 = 1'b1;
    @(negedge clk2);
    chk("t4_regrant_send", 32'(per_send), 32'd1);
    chk("t4_regrant_id", 32'(grant_id), 32'd1);
    per_ack = 1'b1;
    @(negedge clk2);
    cpu_send = '0;
    @(negedge clk2);
    per_ack = 1'b0;
    @(negedge clk2);

    // 5: latched data stays put while the requester changes its word
    do_reset();
    cpu_dado = 8'b0000_0001;
    cpu_send = 4'b0001;
    wait_send_high(5);
    chk("t5_dado_latch", 32'(per_dado), 32'd1);
    cpu_dado = 8'b0000_0010;
    repeat (3) begin
      @(negedge clk2);
      chk("t5_dado_req", 32'(per_dado), 32'd1);
    end
    per_ack = 1'b1;
    @(negedge clk2);
    cpu_send = '0;
    @(negedge clk2);
    per_ack = 1'b0;
    @(negedge clk2);
    chk("t5_dado_after", 32'(per_dado), 32'd1);

    // 6: ack arrives in the same cycle the watchdog reaches its last count
    do_reset();
    cpu_send = 4'b0001;
    wait_send_high(5);
    repeat (15) @(negedge clk2);
    per_ack = 1'b1;
    @(negedge clk2);
    chk("t6_cpu_ack", 32'(cpu_ack), 32'b0001);
    chk("t6_cpu_nak", 32'(cpu_nak), 32'd0);
    chk("t6_err", 32'(err_valid), 32'd0);
    chk("t6_per_send", 32'(per_send), 32'd1);
    cpu_send = '0;
    @(negedge clk2);
    per_ack = 1'b0;
    @(negedge clk2);
    @(negedge clk2);
    chk("t6_idle", 32'(busy), 32'd0);

    model_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
